alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, handshaked successor to the VeriRISC ALU.
- Executes single-cycle arithmetic, logic and shift ops plus an iterative shift-add multiply.
- Registers a result with a status-flag vector.
- Sits between the controller/decoder and the accumulator write-back.
- Keeps the legacy accumulator-zero signal for SKZ.

Parameters:
WIDTH, 8, datapath width in bits (>=4).
MUL_EN, 1, 1 = OP_MUL implemented; 0 = OP_MUL treated as an illegal opcode.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
op  in  4  alu_op_t opcode
a  in  WIDTH  accumulator operand
b  in  WIDTH  data operand
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  registered result
flags  out  4  alu_flags_t {z, n, c, v}, registered
err  out  1  registered; illegal opcode for the held result
acc_zero  out  1  combinational (a == 0), independent of the handshake

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, flags=0, err=0, in_ready=1. Reset mid-MUL aborts the multiply with no output.
- Accept: occurs on a rising edge where in_valid && in_ready. a, b and op are captured at that edge and do not need to be held afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Output handshake: out_valid=1 only in DONE. A result leaves on out_valid && out_ready. result, flags and err stay stable while out_valid && !out_ready.
- FSM:
  - IDLE -accept single-cycle op-> DONE
  - IDLE -accept MUL-> BUSY
  - BUSY -(cnt==0)-> DONE
  - DONE -out_ready && accept single-cycle-> DONE (back-to-back)
  - DONE -out_ready && accept MUL-> BUSY
  - DONE -out_ready, no accept-> IDLE
- Latency and throughput:
  - Single-cycle ops: out_valid high in the cycle after the accept edge; throughput 1 per cycle when out_ready=1.
  - MUL: on accept, load cnt=WIDTH-1, multiplicand=a, multiplier=b, product=0. Each BUSY cycle adds the multiplicand if multiplier[0] is set, then shifts the multiplicand left and the multiplier right. out_valid rises exactly WIDTH cycles after accept. in_ready=0 throughout BUSY.
- Ops (unsigned unless stated); shift amount sh = b[$clog2(WIDTH)-1:0]:
  - PASSA: result=a
  - LDA: result=b
  - ADD: a+b; c=carry out
  - SUB: a-b; c=borrow (a<b unsigned)
  - AND, OR, XOR: bitwise
  - SHL: a<<sh
  - SHR: a>>sh (logical)
  - SAR: a>>>sh (arithmetic)
  - MUL: low WIDTH bits of a*b
  - CMP: computes SUB flags; result=a
- Flags:
  - z = (result==0); for CMP, z is taken from the difference.
  - n = MSB of the value z is taken from.
  - v = signed overflow for ADD/SUB/CMP, 0 otherwise.
  - c for shifts = last bit shifted out; 0 when sh==0.
  - c=0 for logic ops, PASSA, LDA and MUL.
- Illegal op (and OP_MUL when MUL_EN=0): completes as a single-cycle op with result=a, flags from result, err=1. err=0 for all legal ops.
- acc_zero tracks the current a combinationally, in every state and during reset.

Decomposition:
- Add to definitions_pkg:
  - typedef enum logic [3:0] alu_op_t: OP_PASSA=0, OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SAR, OP_MUL, OP_CMP=11; 12–15 illegal.
  - typedef struct packed alu_flags_t {z, n, c, v}.
  - typedef enum of the FSM states.
- Sub-module alu_mul_iter:
  - Owns the iterative multiplier registers and counter.
  - Interface: start pulse, a, b in; done pulse and product out; synchronous clear on rst.
- The top level holds the FSM, single-cycle datapath and output registers.

Test Plan (WIDTH=8):
1. ADD a=03 b=02, out_ready=1 -> next cycle out_valid=1, result=05, flags z0 n0 c0 v0, err=0.
2. ADD 7F+01 -> 80, n1 v1 c0. ADD FF+01 -> 00, z1 c1. SUB 03-05 -> FE, c1 n1. CMP 05,05 -> result 05, z1.
3. MUL 0C*0B -> result 84 with out_valid exactly 8 cycles after accept, in_ready=0 throughout BUSY. Hold out_ready=0 for 3 cycles -> result stays 84; then in_ready follows out_ready.
4. Four back-to-back ops (XOR AA^55, SHL 81<<1, SAR 80>>>3, AND FF&0F) with out_ready=1 -> results FF (c0), 02 (c1), F0, 0F on 4 consecutive cycles. Toggle a to 00 -> acc_zero=1 in the same cycle.
5. Assert rst 3 cycles into MUL -> next cycle out_valid=0, in_ready=1, result=00, flags=0; the following MUL 02*03 -> 06.
6. op=4'hF, a=42 -> result 42, err=1. With MUL_EN=0, OP_MUL a=42 -> single-cycle, err=1, result 42.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the handshaked ALU: opcodes, status flags and FSM states.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_PASSA = 4'd0,
    OP_LDA   = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_SAR   = 4'd9,
    OP_MUL   = 4'd10,
    OP_CMP   = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int FLAGS_W = 4;

endpackage : alu_pipe_pkg

// File: rtl/alu_pipe_if.sv
// Request/response bus between the decoder, the ALU and accumulator write-back.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  import alu_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  alu_flags_t       flags;
  logic             err;
  logic             acc_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, err, acc_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, err, acc_zero
  );

endinterface : alu_pipe_if

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_prod_next;

  assign w_addend    = r_mplier[0] ? r_mcand : {WIDTH{1'b0}};
  assign w_prod_next = r_prod + w_addend;

  // The final partial product is offered combinationally so the caller can
  // register it on the same edge as the last iteration.
  assign o_done    = r_busy && (r_cnt == {CW{1'b0}});
  assign o_product = w_prod_next;

  // Operand load on start, then one add-and-shift step per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_prod   <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CW'(WIDTH - 1);
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_prod   <= {WIDTH{1'b0}};
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == {CW{1'b0}}) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

endmodule : alu_mul_iter

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath, iterative multiply, registered result/flags/err.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_t       r_state;
  alu_state_t       w_state_next;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic signed [WIDTH:0] w_sar;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_zval;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic             w_cmp;
  alu_flags_t       w_flags;

  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;
  alu_flags_t       w_mul_flags;

  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (MUL_EN != 0) && (bus.op == OP_MUL);

  assign w_sh   = bus.b[SHW-1:0];
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  // One guard bit beside the operand catches the last bit shifted out.
  assign w_shl  = {1'b0, bus.a} << w_sh;
  assign w_shr  = {bus.a, 1'b0} >> w_sh;
  assign w_sar  = $signed({bus.a, 1'b0}) >>> w_sh;

  // Single-cycle result, carry/overflow and error for the opcode being accepted.
  always_comb begin
    w_res = bus.a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    w_cmp = 1'b0;
    case (bus.op)
      OP_PASSA: w_res = bus.a;
      OP_LDA:   w_res = bus.b;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
      end
      OP_AND:   w_res = bus.a & bus.b;
      OP_OR:    w_res = bus.a | bus.b;
      OP_XOR:   w_res = bus.a ^ bus.b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SAR: begin
        w_res = w_sar[WIDTH:1];
        w_c   = w_sar[0];
      end
      OP_CMP: begin
        w_res = bus.a;
        w_c   = w_diff[WIDTH];
        w_v   = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
        w_cmp = 1'b1;
      end
      // OP_MUL only lands here when the multiplier is not built in.
      default: begin
        w_res = bus.a;
        w_err = 1'b1;
      end
    endcase
    if (w_cmp) begin
      w_zval = w_diff[WIDTH-1:0];
    end else begin
      w_zval = w_res;
    end
    w_flags.z = (w_zval == {WIDTH{1'b0}});
    w_flags.n = w_zval[MSB];
    w_flags.c = w_c;
    w_flags.v = w_v;
  end

  // Multiply flags depend only on the product.
  always_comb begin
    w_mul_flags.z = (w_mul_prod == {WIDTH{1'b0}});
    w_mul_flags.n = w_mul_prod[MSB];
    w_mul_flags.c = 1'b0;
    w_mul_flags.v = 1'b0;
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // Next-state logic for the request/busy/result-held sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
        end else if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output registers: load on a single-cycle accept or on multiply completion, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= {WIDTH{1'b0}};
      r_flags  <= 4'b0000;
      r_err    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_flags  <= w_flags;
      r_err    <= w_err;
    end else if ((r_state == ST_BUSY) && w_mul_done) begin
      r_result <= w_mul_prod;
      r_flags  <= w_mul_flags;
      r_err    <= 1'b0;
    end else begin
      r_result <= r_result;
      r_flags  <= r_flags;
      r_err    <= r_err;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.err       = r_err;
  assign bus.acc_zero  = (bus.a == {WIDTH{1'b0}});

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: arithmetic flags, multiply timing, back-pressure, reset abort, illegal ops.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8)) bus ();
  alu_pipe_if #(.WIDTH(8)) bus2 ();

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_PASSA;
    bus.a         = 8'h01;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.op        = OP_PASSA;
    bus2.a         = 8'h00;
    bus2.b         = 8'h00;
    bus2.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_result",    {24'd0, bus.result},    32'h00);
    chk("rst_flags",     {28'd0, bus.flags},     32'h0);
    chk("rst_err",       {31'd0, bus.err},       32'd0);
    rst = 1'b0;

    // Add/sub/cmp flag cases, issued back to back
    drive(OP_ADD, 8'h03, 8'h02);
    tick();
    chk("add1_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("add1_result", {24'd0, bus.result},    32'h05);
    chk("add1_flags",  {28'd0, bus.flags},     32'b0000);
    chk("add1_err",    {31'd0, bus.err},       32'd0);
    drive(OP_ADD, 8'h7F, 8'h01);
    tick();
    chk("add2_result", {24'd0, bus.result}, 32'h80);
    chk("add2_flags",  {28'd0, bus.flags},  32'b0101);
    drive(OP_ADD, 8'hFF, 8'h01);
    tick();
    chk("add3_result", {24'd0, bus.result}, 32'h00);
    chk("add3_flags",  {28'd0, bus.flags},  32'b1010);
    drive(OP_SUB, 8'h03, 8'h05);
    tick();
    chk("sub_result", {24'd0, bus.result}, 32'hFE);
    chk("sub_flags",  {28'd0, bus.flags},  32'b0110);
    drive(OP_CMP, 8'h05, 8'h05);
    tick();
    chk("cmp_result", {24'd0, bus.result}, 32'h05);
    chk("cmp_flags",  {28'd0, bus.flags},  32'b1000);
    drive(OP_LDA, 8'h11, 8'h9C);
    tick();
    chk("lda_result", {24'd0, bus.result}, 32'h9C);
    chk("lda_flags",  {28'd0, bus.flags},  32'b0100);
    bus.in_valid = 1'b0;
    tick();
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Multiply: 8-cycle latency, back-pressure hold
    drive(OP_MUL, 8'h0C, 8'h0B);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    for (int i = 0; i < 7; i++) begin
      chk("mul_busy_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mul_busy_ready", {31'd0, bus.in_ready},  32'd0);
      tick();
    end
    chk("mul_busy_valid_last", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("mul_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("mul_result", {24'd0, bus.result},    32'h84);
    chk("mul_flags",  {28'd0, bus.flags},     32'b0100);
    chk("mul_err",    {31'd0, bus.err},       32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid",  {31'd0, bus.out_valid}, 32'd1);
      chk("hold_result", {24'd0, bus.result},    32'h84);
      chk("hold_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("ready_follows", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("mul_drained", {31'd0, bus.out_valid}, 32'd0);

    // Four back-to-back single-cycle ops
    drive(OP_XOR, 8'hAA, 8'h55);
    tick();
    chk("xor_result", {24'd0, bus.result}, 32'hFF);
    chk("xor_flags",  {28'd0, bus.flags},  32'b0100);
    drive(OP_SHL, 8'h81, 8'h01);
    tick();
    chk("shl_result", {24'd0, bus.result}, 32'h02);
    chk("shl_flags",  {28'd0, bus.flags},  32'b0010);
    drive(OP_SAR, 8'h80, 8'h03);
    tick();
    chk("sar_result", {24'd0, bus.result}, 32'hF0);
    chk("sar_flags",  {28'd0, bus.flags},  32'b0100);
    drive(OP_AND, 8'hFF, 8'h0F);
    tick();
    chk("and_result", {24'd0, bus.result},    32'h0F);
    chk("and_valid",  {31'd0, bus.out_valid}, 32'd1);
    drive(OP_SHR, 8'h05, 8'h01);
    tick();
    chk("shr_result", {24'd0, bus.result}, 32'h02);
    chk("shr_flags",  {28'd0, bus.flags},  32'b0010);
    bus.in_valid = 1'b0;
    bus.a = 8'h00;
    #1;
    chk("acc_zero_hi", {31'd0, bus.acc_zero}, 32'd1);
    bus.a = 8'h01;
    #1;
    chk("acc_zero_lo", {31'd0, bus.acc_zero}, 32'd0);
    tick();

    // Reset three cycles into a multiply aborts it
    drive(OP_MUL, 8'h05, 8'h07);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("abort_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("abort_result", {24'd0, bus.result},    32'h00);
    chk("abort_flags",  {28'd0, bus.flags},     32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_output", {31'd0, bus.out_valid}, 32'd0);
    end
    drive(OP_MUL, 8'h02, 8'h03);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("mul2_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("mul2_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("mul2_result", {24'd0, bus.result},    32'h06);
    chk("mul2_flags",  {28'd0, bus.flags},     32'b0000);
    tick();

    // Illegal opcode, and multiply on the build without a multiplier
    drive(alu_op_t'(4'hF), 8'h42, 8'h13);
    tick();
    chk("ill_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("ill_result", {24'd0, bus.result},    32'h42);
    chk("ill_err",    {31'd0, bus.err},       32'd1);
    chk("ill_flags",  {28'd0, bus.flags},     32'b0000);
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.op       = OP_MUL;
    bus2.a        = 8'h42;
    bus2.b        = 8'h03;
    tick();
    bus2.in_valid = 1'b0;
    chk("nomul_valid",  {31'd0, bus2.out_valid}, 32'd1);
    chk("nomul_result", {24'd0, bus2.result},    32'h42);
    chk("nomul_err",    {31'd0, bus2.err},       32'd1);
    chk("legal_err_after", {31'd0, bus.err},     32'd1);
    tick();
    chk("nomul_idle", {31'd0, bus2.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_pipe
